// File: rtl/sm_display_scan_pkg.sv
// Shared constants for the 7-segment scan driver: the hex glyph table and
// the segment bit positions (gfedcba in bits 6..0, decimal point in bit 7).
package sm_display_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba glyphs, indexed by nibble value (entry 0 is rightmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sm_display_scan_if.sv
// Bundle between the register-readout source and the display scan driver.
// There is no handshake: value/dp/blankLz are sampled only at a frame
// boundary, and frameDone is the one-cycle notice that a sample was taken.
interface sm_display_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                blankLz;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig;
  logic                frameDone;

  modport master (
    output value, dp, blankLz,
    input  seg, dig, frameDone
  );

  modport slave (
    input  value, dp, blankLz,
    output seg, dig, frameDone
  );
endinterface

// File: rtl/sm_display_scan_hex2seg.sv
// Combinational nibble to active-high gfedcba glyph decoder.
module sm_hex2seg
  import sm_display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/sm_display_scan.sv
// Time-multiplexed common-anode hex display driver with a frame-synchronous
// snapshot, leading-zero suppression and blank gaps between digit slots.
module sm_display_scan
  import sm_display_scan_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic               clkIn,
  input logic               rst_n,
  sm_display_scan_if.slave  bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_value_q, snap_value_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                snap_blank_lz_q, snap_blank_lz_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end, frame_end, zero_above;
  logic [DIGITS-1:0]   lz_mask, idx_onehot, dig_hi;
  logic [3:0]          cur_nibble;
  logic                cur_dp, cur_hidden;
  logic [6:0]          cur_glyph;
  logic [7:0]          seg_hi;

  always_comb begin
    slot_end        = (div_cnt_q == DIV_LAST);
    frame_end       = slot_end && (idx_q == IDX_LAST);
    div_cnt_d       = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d           = idx_q;
    snap_value_d    = snap_value_q;
    snap_dp_d       = snap_dp_q;
    snap_blank_lz_d = snap_blank_lz_q;
    frame_done_d    = frame_end;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // The only place the snapshot loads, so a frame never mixes two values.
    if (frame_end) begin
      snap_value_d    = bus.value;
      snap_dp_d       = bus.dp;
      snap_blank_lz_d = bus.blankLz;
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero;
  // digit 0 is never a candidate, and a lit decimal point keeps it visible.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (snap_value_q[4*k +: 4] == 4'h0);
      lz_mask[k] = snap_blank_lz_q && zero_above && !snap_dp_q[k];
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_hidden = 1'b0;
    idx_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nibble    = snap_value_q[4*k +: 4];
        cur_dp        = snap_dp_q[k];
        cur_hidden    = lz_mask[k];
        idx_onehot[k] = 1'b1;
      end
    end
  end

  sm_hex2seg u_hex2seg (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  always_comb begin
    seg_hi = {1'b0, SEG_BLANK};
    dig_hi = '0;
    if ((div_cnt_q >= BLANK_END) && !cur_hidden) begin
      seg_hi[SEG_G:SEG_A] = cur_glyph;
      seg_hi[SEG_DP]      = cur_dp;
      dig_hi              = idx_onehot;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dig_d = DIG_ACTIVE_LOW ? ~dig_hi : dig_hi;
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q       <= '0;
      idx_q           <= '0;
      snap_value_q    <= '0;
      snap_dp_q       <= '0;
      snap_blank_lz_q <= 1'b0;
      seg_q           <= SEG_OFF;
      dig_q           <= DIG_OFF;
      frame_done_q    <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      idx_q           <= idx_d;
      snap_value_q    <= snap_value_d;
      snap_dp_q       <= snap_dp_d;
      snap_blank_lz_q <= snap_blank_lz_d;
      seg_q           <= seg_d;
      dig_q           <= dig_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dig       = dig_q;
  assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_sm_display_scan.sv
// Bench for sm_display_scan with 4 digits, 8-cycle slots and 2 blank cycles,
// active-low outputs. Expected lit digits are queued per frame as {dig, seg}.
module tb_sm_display_scan;
  localparam int DIGITS = 4;
  localparam int NV     = 9;

  logic clk;
  logic rst_n;

  sm_display_scan_if #(.DIGITS(DIGITS)) bus ();

  sm_display_scan #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clkIn (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // directed vectors: inputs, cycles to wait before driving them, and the
  // hand-decoded lit digits {dig, seg} of the frame that will show them
  logic [15:0] v_val [NV];
  logic [3:0]  v_dp  [NV];
  logic        v_blz [NV];
  int          v_dly [NV];
  int          v_n   [NV];
  logic [11:0] v_exp [NV][4];

  initial begin
    v_val[0] = 16'h1234; v_dp[0] = 4'b0000; v_blz[0] = 1'b0; v_dly[0] = 0;
    v_n[0] = 4; v_exp[0] = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};
    // driven mid-frame (slot idx1) while 1234 is on display
    v_val[1] = 16'hABCD; v_dp[1] = 4'b0000; v_blz[1] = 1'b1; v_dly[1] = 12;
    v_n[1] = 4; v_exp[1] = '{12'hEA1, 12'hDC6, 12'hB83, 12'h788};
    v_val[2] = 16'h0050; v_dp[2] = 4'b0000; v_blz[2] = 1'b1; v_dly[2] = 0;
    v_n[2] = 2; v_exp[2] = '{12'hEC0, 12'hD92, 12'h000, 12'h000};
    v_val[3] = 16'h0000; v_dp[3] = 4'b0000; v_blz[3] = 1'b1; v_dly[3] = 0;
    v_n[3] = 1; v_exp[3] = '{12'hEC0, 12'h000, 12'h000, 12'h000};
    v_val[4] = 16'h0000; v_dp[4] = 4'b0100; v_blz[4] = 1'b1; v_dly[4] = 0;
    v_n[4] = 2; v_exp[4] = '{12'hEC0, 12'hB40, 12'h000, 12'h000};
    v_val[5] = 16'h0000; v_dp[5] = 4'b1000; v_blz[5] = 1'b1; v_dly[5] = 0;
    v_n[5] = 2; v_exp[5] = '{12'hEC0, 12'h740, 12'h000, 12'h000};
    v_val[6] = 16'h0800; v_dp[6] = 4'b0000; v_blz[6] = 1'b1; v_dly[6] = 0;
    v_n[6] = 3; v_exp[6] = '{12'hEC0, 12'hDC0, 12'hB80, 12'h000};
    v_val[7] = 16'h00A0; v_dp[7] = 4'b0001; v_blz[7] = 1'b0; v_dly[7] = 5;
    v_n[7] = 4; v_exp[7] = '{12'hE40, 12'hD88, 12'hBC0, 12'h7C0};
    v_val[8] = 16'hEF96; v_dp[8] = 4'b0000; v_blz[8] = 1'b0; v_dly[8] = 0;
    v_n[8] = 4; v_exp[8] = '{12'hE82, 12'hD90, 12'hB8E, 12'h786};
  end

  // driver tasks
  task automatic drive(input logic [15:0] val, input logic [3:0] dpv, input logic blz);
    bus.value   = val;
    bus.dp      = dpv;
    bus.blankLz = blz;
  endtask

  task automatic push_zero_frame();
    exp_q.push_back(12'hEC0);
    exp_q.push_back(12'hDC0);
    exp_q.push_back(12'hBC0);
    exp_q.push_back(12'h7C0);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frameDone && n < 100);
    check("frame_done_seen", 32'(bus.frameDone), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // monitor / scoreboard
  initial begin
    logic [DIGITS-1:0] prev_dig;
    int lit_cnt, gap_cnt, fd_cnt, zeros;
    logic [11:0] exp;
    prev_dig = '1; lit_cnt = 0; gap_cnt = 0; fd_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_dig = '1; lit_cnt = 0; gap_cnt = 0; fd_cnt = 0;
      end else begin
        fd_cnt++;
        if (bus.frameDone) begin
          check("frame_period", fd_cnt, 32);
          fd_cnt = 0;
        end
        zeros = 0;
        for (int k = 0; k < DIGITS; k++) if (!bus.dig[k]) zeros++;
        check("dig_onehot", 32'(zeros <= 1), 32'd1);
        if (bus.dig != '1) begin
          if (bus.dig != prev_dig) begin
            if (prev_dig != '1) check("lit_run", lit_cnt, 6);
            check("gap_len_mod_slot", gap_cnt % 8, 2);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL digit_event: got 0x%0h required none", {bus.dig, bus.seg});
            end else begin
              exp = exp_q.pop_front();
              check("digit_event", {20'd0, bus.dig, bus.seg}, {20'd0, exp});
            end
            lit_cnt = 0;
            gap_cnt = 0;
          end
          lit_cnt++;
        end else begin
          if (prev_dig != '1) check("lit_run", lit_cnt, 6);
          check("blank_seg", 32'(bus.seg), 32'hFF);
          gap_cnt++;
        end
        prev_dig = bus.dig;
      end
    end
  end

  // main sequence
  initial begin
    int cnt;
    rst_n = 1'b1;
    drive(16'hFFFF, 4'hF, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_seg", 32'(bus.seg), 32'hFF);
    check("reset_dig", 32'(bus.dig), 32'hF);
    check("reset_frame_done", 32'(bus.frameDone), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_seg", 32'(bus.seg), 32'hFF);
      check("reset_hold_dig", 32'(bus.dig), 32'hF);
      check("reset_hold_fd", 32'(bus.frameDone), 32'd0);
    end

    // first frame after reset shows the zero snapshot with suppression off
    push_zero_frame();
    #1 rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      wait_cycles(v_dly[i]);
      drive(v_val[i], v_dp[i], v_blz[i]);
      wait_fd();
      for (int j = 0; j < v_n[i]; j++) exp_q.push_back(v_exp[i][j]);
    end

    // async reset dropped between edges during slot idx2 of a 5678 frame
    drive(16'h5678, 4'h0, 1'b0);
    wait_fd();
    exp_q.push_back(12'hE80);
    exp_q.push_back(12'hDF8);
    exp_q.push_back(12'hB82);
    wait_cycles(20);
    check("pre_reset_dig_idx2", 32'(bus.dig), 32'hB);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_seg", 32'(bus.seg), 32'hFF);
    check("midreset_dig", 32'(bus.dig), 32'hF);
    check("midreset_fd", 32'(bus.frameDone), 32'd0);
    check("midreset_queue_drained", exp_q.size(), 0);
    drive(16'h4321, 4'h0, 1'b0);
    wait_cycles(2);
    push_zero_frame();
    #1 rst_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.dig == '1 && cnt < 20);
    check("first_lit_latency", cnt, 3);
    check("first_lit_dig", 32'(bus.dig), 32'hE);
    wait_fd();
    exp_q.push_back(12'hEF9);
    exp_q.push_back(12'hDA4);
    exp_q.push_back(12'hBB0);
    exp_q.push_back(12'h799);
    wait_fd();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
